// File: rtl/imem_hs.sv
// Byte-loadable instruction memory with a single-outstanding valid/ready fetch port.
// Fetches return a 32-bit word after a fixed latency; faulting fetches return a NOP with rsp_err set.
module imem_hs #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter int          BIG_ENDIAN  = 1,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [31:0]                         req_addr,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [31:0]                         rsp_inst,
    output logic                                rsp_err,
    input  logic                                ld_start,
    input  logic                                ld_valid,
    input  logic [7:0]                          ld_byte,
    input  logic                                ld_last,
    output logic                                ld_busy,
    output logic [$clog2(4*DEPTH_WORDS):0]      ld_count,
    output logic                                ld_ovf
);

    localparam int              BYTES    = 4 * DEPTH_WORDS;
    localparam int              AW       = $clog2(BYTES);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   BYTES_C  = CW'(BYTES);
    localparam logic [1:0]      LAT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_e;

    state_e          state_q, state_d;
    logic [1:0]      lat_cnt_q, lat_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     rsp_inst_q, rsp_inst_d;
    logic            rsp_err_q, rsp_err_d;
    logic [CW-1:0]   ld_count_q, ld_count_d;
    logic            ld_ovf_q, ld_ovf_d;
    logic            mem_we;

    logic [7:0]      mem [BYTES];

    logic [31:0]     fetch_addr;
    logic            fault;
    logic [AW-3:0]   word_idx;
    logic [31:0]     rd_word;

    // With LATENCY=1 the response is loaded on the acceptance edge, so the live request address is used.
    always_comb begin
        fetch_addr = (state_q == IDLE) ? req_addr : addr_q;
        fault      = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH_WORDS));
        word_idx   = fault ? '0 : fetch_addr[AW-1:2];
        if (BIG_ENDIAN != 0) begin
            rd_word = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};
        end else begin
            rd_word = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                       mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = addr_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        ld_count_d = ld_count_q;
        ld_ovf_d   = ld_ovf_q;
        mem_we     = 1'b0;
        req_ready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = rst_n && !ld_start;
                if (ld_start) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                    ld_ovf_d   = 1'b0;
                end else if (req_valid) begin
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        rsp_inst_d = fault ? NOP_INST : rd_word;
                        rsp_err_d  = fault;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d    = RESP;
                    rsp_inst_d = fault ? NOP_INST : rd_word;
                    rsp_err_d  = fault;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            LOAD: begin
                if (ld_valid) begin
                    if (ld_count_q < BYTES_C) begin
                        mem_we     = 1'b1;
                        ld_count_d = ld_count_q + CW'(1);
                    end else begin
                        ld_ovf_d = 1'b1;
                    end
                    if (ld_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 2'd0;
            addr_q     <= 32'd0;
            rsp_inst_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            ld_count_q <= '0;
            ld_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
            ld_count_q <= ld_count_d;
            ld_ovf_q   <= ld_ovf_d;
        end
    end

    // NOTE: the array has no reset so program contents survive rst_n and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[ld_count_q[AW-1:0]] <= ld_byte;
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;
    assign ld_busy   = (state_q == LOAD);
    assign ld_count  = ld_count_q;
    assign ld_ovf    = ld_ovf_q;

endmodule

// File: tb/tb_imem_hs.sv
// Randomized scoreboard bench for imem_hs: a byte-array reference model predicts each fetch,
// and an independent monitor checks latency, data and hold stability of every response.
module tb_imem_hs;

    localparam int          DEPTH = 4;
    localparam int          LAT   = 3;
    localparam int          BE    = 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NB    = 4 * DEPTH;
    localparam int          CW    = $clog2(NB) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_inst;
    logic          rsp_err;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic          ld_busy;
    logic [CW-1:0] ld_count;
    logic          ld_ovf;

    imem_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BIG_ENDIAN(BE), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_busy(ld_busy), .ld_count(ld_count), .ld_ovf(ld_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_mem [NB];
    int          model_count = 0;
    bit          model_ovf   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        int   i;
        e.acc_cyc = 0;
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
            e.inst = NOP;
            e.err  = 1'b1;
        end else begin
            i = int'(a);
            e.err  = 1'b0;
            e.inst = BE ? {model_mem[i], model_mem[i+1], model_mem[i+2], model_mem[i+3]}
                        : {model_mem[i+3], model_mem[i+2], model_mem[i+1], model_mem[i]};
        end
        return e;
    endfunction

    // Monitor: pops the expectation on the first cycle of each response and re-checks it while held.
    initial begin : monitor
        exp_t cur;
        bit   in_rsp = 0;
        cur = '{inst: '0, err: 1'b0, acc_cyc: 0};
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got inst %h with no fetch outstanding", rsp_inst);
                    end else begin
                        cur = exp_q.pop_front();
                        check("rsp_latency_cycle", cyc, cur.acc_cyc + LAT);
                        in_rsp = 1;
                    end
                end
                if (in_rsp) begin
                    check("rsp_inst", rsp_inst, cur.inst);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                end
                if (rsp_ready) in_rsp = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int hold, input bit pulse_ld);
        exp_t e;
        int   t;
        req_addr  = a;
        req_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 20) begin
                check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        e = model_fetch(a);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        if (pulse_ld) begin
            ld_start = 1'b1;
            @(posedge clk); #1;
            ld_start = 1'b0;
            check("ld_start_ignored_busy", {31'd0, ld_busy}, 32'd0);
        end
        t = 0;
        while (!rsp_valid) begin
            @(posedge clk); #1;
            t++;
            if (t > 20) begin
                check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
                return;
            end
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
        check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic load(input logic [7:0] data[$], input bit send_last);
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        model_count = 0;
        model_ovf   = 0;
        check("ld_busy_in_load", {31'd0, ld_busy}, 32'd1);
        for (int i = 0; i < data.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_byte  = data[i];
            ld_last  = send_last && (i == data.size() - 1);
            @(posedge clk); #1;
            if (model_count < NB) begin
                model_mem[model_count] = data[i];
                model_count++;
            end else begin
                model_ovf = 1;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ld_busy_after_bytes", {31'd0, ld_busy}, {31'd0, !send_last});
        check("ld_count", 32'(ld_count), 32'(model_count));
        check("ld_ovf", {31'd0, ld_ovf}, {31'd0, model_ovf});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] d[$];
        logic [31:0] a;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_inst", rsp_inst, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ld_busy", {31'd0, ld_busy}, 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_ld_ovf", {31'd0, ld_ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("req_ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic program load and two fetches
        d = '{8'h00, 8'h00, 8'h00, 8'h13, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load(d, 1'b1);
        fetch(32'h0, 0, 1'b0);
        fetch(32'h4, 0, 1'b0);

        // Latency with back-pressure held three cycles
        fetch(32'h0, 3, 1'b0);

        // Faulting fetches: misaligned and first out-of-range word
        fetch(32'h2, 1, 1'b0);
        fetch(32'(NB), 0, 1'b0);

        // Overflowing load of 20 bytes into 16-byte memory
        d = {};
        for (int i = 0; i < 20; i++) d.push_back(8'($urandom));
        load(d, 1'b1);
        for (int w = 0; w < DEPTH; w++) fetch(32'(4 * w), $urandom_range(0, 2), 1'b0);

        // ld_start wins over same-cycle req_valid
        ld_start  = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #1;
        check("req_ready_during_ld_start", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        ld_start  = 1'b0;
        req_valid = 1'b0;
        check("ld_busy_after_collision", {31'd0, ld_busy}, 32'd1);
        check("ld_count_cleared", 32'(ld_count), 32'd0);
        check("ld_ovf_cleared", {31'd0, ld_ovf}, 32'd0);
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(d, 1'b1);
        fetch(32'h0, 0, 1'b0);

        // ld_start while a fetch is pending is ignored; ld_valid outside LOAD is ignored
        fetch(32'h4, 1, 1'b1);
        ld_valid = 1'b1;
        ld_byte  = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        check("ld_count_idle_ld_valid", 32'(ld_count), 32'(model_count));
        fetch(32'h0, 0, 1'b0);

        // Reset in the middle of a load keeps the written bytes
        d = {};
        for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
        load(d, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midload_rst_ld_busy", {31'd0, ld_busy}, 32'd0);
        check("midload_rst_ld_count", 32'(ld_count), 32'd0);
        rst_n = 1'b1;
        model_count = 0;
        model_ovf   = 0;
        fetch(32'h0, 0, 1'b0);
        fetch(32'h4, 0, 1'b0);

        // Randomized mix of fetches and reloads
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) begin
                d = {};
                for (int i = 0; i < $urandom_range(1, 20); i++) d.push_back(8'($urandom));
                load(d, 1'b1);
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 32'($urandom_range(0, NB - 1)) | 32'd1;
                    1: a = ($urandom_range(0, 1) != 0) ? ($urandom | 32'h8000_0000)
                                                        : (32'($urandom_range(NB, 4 * NB)) & ~32'd3);
                    default: a = 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                fetch(a, $urandom_range(0, 3), 1'b0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_hs.md
IMEM_HS -- requirements
Module: imem_hs

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: memory capacity in 32-bit words; byte array depth is 4*DEPTH_WORDS.
REQ-002 Parameter LATENCY, default 1, legal 1..4: cycles from request acceptance to first rsp_valid.
REQ-003 Parameter BIG_ENDIAN, default 1: 1 = word is {mem[a],mem[a+1],mem[a+2],mem[a+3]}; 0 = {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
REQ-004 Parameter NOP_INST, default 32'h00000013: word returned on any faulting fetch.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  fetch request present.
REQ-008 req_ready  output  1  block can accept a fetch this cycle.
REQ-009 req_addr  input  32  byte address of the fetch.
REQ-010 rsp_valid  output  1  rsp_inst/rsp_err valid.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_inst  output  32  fetched instruction word.
REQ-013 rsp_err  output  1  fetch faulted (misaligned or out of range).
REQ-014 ld_start  input  1  single-cycle pulse: begin program load at byte 0.
REQ-015 ld_valid  input  1  ld_byte is valid this cycle.
REQ-016 ld_byte  input  8  program byte to write.
REQ-017 ld_last  input  1  qualifies ld_valid: final byte of program.
REQ-018 ld_busy  output  1  load in progress.
REQ-019 ld_count  output  $clog2(4*DEPTH_WORDS)+1  bytes written in current/last load.
REQ-020 ld_ovf  output  1  sticky: load byte dropped past capacity.

Function
REQ-021 FSM states IDLE, WAIT, RESP, LOAD; single outstanding fetch.
REQ-022 req_ready = 1 only in IDLE; fetch accepted on req_valid && req_ready; req_addr captured at acceptance.
REQ-023 IDLE -> WAIT on acceptance; WAIT holds LATENCY-1 cycles (down-counter), LATENCY=1 skips WAIT and enters RESP directly.
REQ-024 rsp_valid asserted exactly LATENCY cycles after acceptance cycle; rsp_inst/rsp_err held stable while rsp_valid && !rsp_ready.
REQ-025 RESP -> IDLE on rsp_valid && rsp_ready; rsp_valid deasserts next cycle; peak throughput one fetch per LATENCY+1 cycles.
REQ-026 Fault rules, evaluated on captured address: addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS -> rsp_err=1, rsp_inst=NOP_INST; else rsp_err=0 and word per BIG_ENDIAN; no array read beyond bounds.
REQ-027 IDLE -> LOAD on ld_start; ld_start has priority over a same-cycle req_valid (req_ready=0 that cycle); ld_count cleared to 0, ld_ovf cleared.
REQ-028 ld_start outside IDLE ignored; ld_valid outside LOAD ignored.
REQ-029 In LOAD, each ld_valid writes ld_byte at byte index ld_count then ld_count increments; when ld_count == 4*DEPTH_WORDS byte dropped, ld_count holds, ld_ovf set.
REQ-030 ld_valid && ld_last writes (or drops) that byte and returns LOAD -> IDLE next cycle; ld_busy = 1 exactly in LOAD.
REQ-031 Fetch of a word written in a completed load returns the new bytes; ld_count retains final value after load until next ld_start.

Reset
REQ-032 rst_n low at a clock edge: state IDLE, req_ready=0 during reset and 1 first cycle after, rsp_valid=0, rsp_inst=0, rsp_err=0, ld_busy=0, ld_count=0, ld_ovf=0, latency counter 0.
REQ-033 Memory array is not cleared by reset; bytes written before reset mid-load are retained; pending fetch is discarded with no response.

Verification
REQ-034 Load bytes 00 00 00 13 FF FF FF FF (last flagged), fetch 0x0 then 0x4, BIG_ENDIAN=1 -> 0x00000013 then 0xFFFFFFFF, rsp_err=0, ld_count=8.
REQ-035 LATENCY=3: accept at cycle N -> rsp_valid first high at N+3; hold rsp_ready=0 three cycles -> rsp_inst unchanged; handshake -> req_ready high next cycle.
REQ-036 Fetch 0x2 -> rsp_inst=0x00000013, rsp_err=1; fetch 4*DEPTH_WORDS -> same.
REQ-037 DEPTH_WORDS=4: load 20 bytes -> ld_count=16, ld_ovf=1, words 0..3 hold first 16 bytes.
REQ-038 ld_start and req_valid same IDLE cycle -> LOAD entered, fetch not accepted; ld_start while rsp pending -> ignored, response delivered.
REQ-039 rst_n low after 5 load bytes -> ld_busy=0, ld_count=0, fetch 0x0 returns the first 4 bytes loaded.
